// File: rtl/uart_card_commander_if.sv
// Handshake bundle between uart_card_commander and its UART / card_driver neighbours.
// master = the commander itself, slave = the surrounding UART and card driver.
interface uart_card_commander_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    logic              RX_STB;
    logic [7:0]        RX_DAT;
    logic              RX_ACK;
    logic              TX_STB;
    logic [7:0]        TX_DAT;
    logic              TX_RDY;
    logic              WR_STB;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [LEN_W-1:0]  WR_LENGTH;
    logic              WR_ACK;
    logic              WD_STB;
    logic [7:0]        WD_DATA;
    logic              WD_ACK;
    logic              RD_STB;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [LEN_W-1:0]  RD_LENGTH;
    logic              RD_ACK;
    logic              RES_STB;
    logic [7:0]        RES_DATA;
    logic              RES_BUSY;
    logic [15:0]       DROP_CNT;

    modport master (
        input  RX_STB, RX_DAT, TX_RDY, WR_ACK, WD_ACK, RD_ACK, RES_STB, RES_DATA,
        output RX_ACK, TX_STB, TX_DAT, WR_STB, WR_ADDR, WR_LENGTH, WD_STB, WD_DATA,
               RD_STB, RD_ADDR, RD_LENGTH, RES_BUSY, DROP_CNT
    );

    modport slave (
        output RX_STB, RX_DAT, TX_RDY, WR_ACK, WD_ACK, RD_ACK, RES_STB, RES_DATA,
        input  RX_ACK, TX_STB, TX_DAT, WR_STB, WR_ADDR, WR_LENGTH, WD_STB, WD_DATA,
               RD_STB, RD_ADDR, RD_LENGTH, RES_BUSY, DROP_CNT
    );
endinterface

// File: rtl/uart_card_commander.sv
// Byte-framed UART command front-end for the SD card driver with a shared reply/result FIFO.
// Define PATTERN_LFSR_EN to add the LFSR write-data pattern (pattern mode 2).
module uart_card_commander #(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int FIFO_AW     = 5,
    parameter int BUSY_MARGIN = 4,
    parameter int ARG_TIMEOUT = 5000000,
    parameter int ACK_TIMEOUT = 50000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_card_commander_if.master bus
);
    localparam int AB    = (ADDR_W + 7) / 8;
    localparam int LB    = (LEN_W + 7) / 8;
    localparam int SH_W  = 8 * (AB + LB);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = $clog2(AB + LB + 1);

    localparam logic [7:0] OP_WR = 8'h77, OP_RD = 8'h72, OP_PAT = 8'h70, OP_STAT = 8'h73;
    localparam logic [7:0] CH_K = 8'h4B, CH_E = 8'h45, CH_T = 8'h54, CH_S = 8'h53, CH_Q = 8'h3F;

    localparam logic [1:0] CMD_WR = 2'd0, CMD_RD = 2'd1, CMD_PAT = 2'd2;
    localparam logic [1:0] MODE_INC = 2'd0, MODE_CONST = 2'd1;
`ifdef PATTERN_LFSR_EN
    localparam logic [1:0] MODE_LFSR = 2'd2;
`endif

    typedef enum logic [2:0] {IDLE, ARG, ISSUE, WAIT_ACK, REPLY} state_t;
    state_t state, state_next;

    logic [1:0]       cmd;
    logic [CNT_W-1:0] arg_cnt;
    logic [SH_W-1:0]  arg_sh;
    logic [31:0]      timer;
    logic [7:0]       reply_byte;
    logic [7:0]       status_byte;
    logic             status_pending;
    logic [1:0]       pat_mode;

    logic [7:0]       fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, fifo_count;
    logic             fifo_full, fifo_empty;
    logic [1:0]       holdoff;

    logic             rx_take, rx_drop, last_arg, pat_valid, pat_load, ack_hit;
    logic             reply_push, res_push, res_drop, fifo_we, tx_pop;
    logic [7:0]       fifo_wd, mode_byte, seed_byte, wd_step;
    logic [SH_W-1:0]  arg_sh_next;
    logic [16:0]      drop_sum;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == (FIFO_AW + 1)'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign bus.WD_STB = 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.RX_STB) begin
                    if (bus.RX_DAT == OP_WR || bus.RX_DAT == OP_RD || bus.RX_DAT == OP_PAT)
                        state_next = ARG;
                    else
                        state_next = REPLY;
                end
            end
            ARG: begin
                if (bus.RX_STB) begin
                    if (last_arg) state_next = (cmd == CMD_PAT) ? REPLY : ISSUE;
                end else if (timer >= 32'(ARG_TIMEOUT)) begin
                    state_next = REPLY;
                end
            end
            ISSUE:    state_next = WAIT_ACK;
            WAIT_ACK: if (ack_hit || timer >= 32'(ACK_TIMEOUT)) state_next = REPLY;
            REPLY:    if (reply_push && !status_pending) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Combinational handshakes; a RES byte always wins the single FIFO write port.
    always_comb begin
        rx_take     = bus.RX_STB && (state == IDLE || state == ARG);
        rx_drop     = bus.RX_STB && !rx_take;
        bus.RX_ACK  = rx_take;
        last_arg    = (state == ARG) && (arg_cnt == CNT_W'(1));
        arg_sh_next = {arg_sh[SH_W-9:0], bus.RX_DAT};
        mode_byte   = arg_sh[7:0];
        seed_byte   = bus.RX_DAT;
`ifdef PATTERN_LFSR_EN
        pat_valid   = (mode_byte == 8'd0) || (mode_byte == 8'd1) || (mode_byte == 8'd2);
        if (mode_byte == 8'd2 && bus.RX_DAT == 8'h00) seed_byte = 8'h01;
`else
        pat_valid   = (mode_byte == 8'd0) || (mode_byte == 8'd1);
`endif
        pat_load    = bus.RX_STB && last_arg && (cmd == CMD_PAT) && pat_valid;
        ack_hit     = ((cmd == CMD_WR) && bus.WR_ACK) || ((cmd == CMD_RD) && bus.RD_ACK);
        res_push    = bus.RES_STB && !fifo_full;
        res_drop    = bus.RES_STB && fifo_full;
        reply_push  = (state == REPLY) && !bus.RES_STB && !fifo_full;
        fifo_we     = res_push || reply_push;
        fifo_wd     = res_push ? bus.RES_DATA : reply_byte;
        tx_pop      = !fifo_empty && bus.TX_RDY && (holdoff == 2'd0);
        drop_sum    = {1'b0, bus.DROP_CNT} + 17'(rx_drop) + 17'(res_drop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd            <= CMD_WR;
            arg_cnt        <= '0;
            arg_sh         <= '0;
            timer          <= '0;
            reply_byte     <= '0;
            status_byte    <= '0;
            status_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (bus.RX_STB) begin
                        status_pending <= 1'b0;
                        case (bus.RX_DAT)
                            OP_WR:  begin cmd <= CMD_WR;  arg_cnt <= CNT_W'(AB + LB); end
                            OP_RD:  begin cmd <= CMD_RD;  arg_cnt <= CNT_W'(AB + LB); end
                            OP_PAT: begin cmd <= CMD_PAT; arg_cnt <= CNT_W'(2); end
                            OP_STAT: begin
                                reply_byte     <= CH_S;
                                status_pending <= 1'b1;
                                status_byte    <= {fifo_full, fifo_empty, pat_mode, bus.DROP_CNT[3:0]};
                            end
                            default: reply_byte <= CH_Q;
                        endcase
                    end
                end
                ARG: begin
                    if (bus.RX_STB) begin
                        arg_sh  <= arg_sh_next;
                        arg_cnt <= arg_cnt - CNT_W'(1);
                        timer   <= '0;
                        if (last_arg && cmd == CMD_PAT) reply_byte <= pat_valid ? CH_K : CH_E;
                    end else begin
                        timer <= timer + 32'd1;
                        if (timer >= 32'(ARG_TIMEOUT)) reply_byte <= CH_T;
                    end
                end
                ISSUE: timer <= '0;
                WAIT_ACK: begin
                    timer      <= timer + 32'd1;
                    reply_byte <= ack_hit ? CH_K : CH_E;
                end
                REPLY: begin
                    if (reply_push && status_pending) begin
                        reply_byte     <= status_byte;
                        status_pending <= 1'b0;
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.WR_STB    <= 1'b0;
            bus.RD_STB    <= 1'b0;
            bus.WR_ADDR   <= '0;
            bus.WR_LENGTH <= '0;
            bus.RD_ADDR   <= '0;
            bus.RD_LENGTH <= '0;
        end else begin
            bus.WR_STB <= (state == ISSUE) && (cmd == CMD_WR);
            bus.RD_STB <= (state == ISSUE) && (cmd == CMD_RD);
            if (state == ISSUE && cmd == CMD_WR) begin
                bus.WR_ADDR   <= arg_sh[8*LB +: ADDR_W];
                bus.WR_LENGTH <= arg_sh[LEN_W-1:0];
            end
            if (state == ISSUE && cmd == CMD_RD) begin
                bus.RD_ADDR   <= arg_sh[8*LB +: ADDR_W];
                bus.RD_LENGTH <= arg_sh[LEN_W-1:0];
            end
        end
    end

    always_comb begin
        wd_step = bus.WD_DATA;
        case (pat_mode)
            MODE_INC:   wd_step = bus.WD_DATA + 8'd1;
            MODE_CONST: wd_step = bus.WD_DATA;
`ifdef PATTERN_LFSR_EN
            MODE_LFSR:  wd_step = {bus.WD_DATA[6:0],
                                   bus.WD_DATA[7] ^ bus.WD_DATA[5] ^ bus.WD_DATA[4] ^ bus.WD_DATA[3]};
`endif
            default:    wd_step = bus.WD_DATA;
        endcase
    end

    // A pattern load from the UART overrides the step caused by WD_ACK in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pat_mode    <= MODE_INC;
            bus.WD_DATA <= 8'h41;
        end else if (pat_load) begin
            pat_mode    <= mode_byte[1:0];
            bus.WD_DATA <= seed_byte;
        end else if (bus.WD_ACK) begin
            bus.WD_DATA <= wd_step;
        end
    end

    always_ff @(posedge CLK) begin
        if (fifo_we) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= fifo_wd;
    end

    // The holdoff lets the transmitter drop TX_RDY before another byte is offered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            holdoff      <= 2'd0;
            bus.TX_STB   <= 1'b0;
            bus.TX_DAT   <= 8'h00;
            bus.RES_BUSY <= 1'b0;
            bus.DROP_CNT <= 16'h0000;
        end else begin
            if (fifo_we) wr_ptr <= wr_ptr + 1'b1;
            bus.TX_STB <= tx_pop;
            if (tx_pop) begin
                bus.TX_DAT <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
                rd_ptr     <= rd_ptr + 1'b1;
                holdoff    <= 2'd2;
            end else if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end
            bus.RES_BUSY <= (fifo_count >= (FIFO_AW + 1)'(DEPTH - BUSY_MARGIN));
            bus.DROP_CNT <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_uart_card_commander.sv
// Scoreboard bench for uart_card_commander: expected TX bytes are queued as commands are sent.
// Honours PATTERN_LFSR_EN the same way as the design.
module tb_uart_card_commander;
    localparam int ARG_TO = 40;
    localparam int ACK_TO = 80;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] exp_q[$];
    logic [1:0] exp_mode;
    logic [15:0] exp_drop;
    logic [7:0] exp_wd;

    uart_card_commander_if #(.ADDR_W(32), .LEN_W(8)) bus ();

    uart_card_commander #(
        .ADDR_W(32), .LEN_W(8), .FIFO_AW(5), .BUSY_MARGIN(4),
        .ARG_TIMEOUT(ARG_TO), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TX scoreboard: every transmitted byte must be the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && bus.TX_STB) begin
            if (exp_q.size() == 0) checkOutput("tx_extra", 32'(bus.TX_DAT), 32'h100);
            else                   checkOutput("tx_byte", 32'(bus.TX_DAT), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [7:0] b, output logic ack);
        @(posedge CLK); #1;
        bus.RX_STB = 1'b1;
        bus.RX_DAT = b;
        @(negedge CLK);
        ack = bus.RX_ACK;
        @(posedge CLK); #1;
        bus.RX_STB = 1'b0;
    endtask

    task automatic sendBytes(input logic [47:0] bytes, input int n, output logic first_ack);
        logic a;
        first_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(bytes[8*(n-1-i) +: 8], a);
            if (i == 0) first_ack = a;
        end
    endtask

    task automatic measureStb(input bit is_wr, output int first, output int width);
        first = 0;
        width = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (is_wr ? bus.WR_STB : bus.RD_STB) begin
                width++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic pulseAck(input int which);
        @(posedge CLK); #1;
        if (which == 0) bus.WR_ACK = 1'b1;
        else if (which == 1) bus.RD_ACK = 1'b1;
        else bus.WD_ACK = 1'b1;
        @(posedge CLK); #1;
        bus.WR_ACK = 1'b0;
        bus.RD_ACK = 1'b0;
        bus.WD_ACK = 1'b0;
        @(negedge CLK);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (4) @(negedge CLK);
    endtask

    function automatic logic [7:0] lfsrStep(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    function automatic logic [7:0] statusByte();
        return {1'b0, 1'b1, exp_mode, exp_drop[3:0]};
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wr_stb"}, 32'(bus.WR_STB), 32'd0);
        checkOutput({tag, "_rd_stb"}, 32'(bus.RD_STB), 32'd0);
        checkOutput({tag, "_tx_stb"}, 32'(bus.TX_STB), 32'd0);
        checkOutput({tag, "_tx_dat"}, 32'(bus.TX_DAT), 32'd0);
        checkOutput({tag, "_wr_addr"}, bus.WR_ADDR, 32'd0);
        checkOutput({tag, "_rd_addr"}, bus.RD_ADDR, 32'd0);
        checkOutput({tag, "_rd_len"}, 32'(bus.RD_LENGTH), 32'd0);
        checkOutput({tag, "_wd_stb"}, 32'(bus.WD_STB), 32'd1);
        checkOutput({tag, "_wd_data"}, 32'(bus.WD_DATA), 32'h41);
        checkOutput({tag, "_res_busy"}, 32'(bus.RES_BUSY), 32'd0);
        checkOutput({tag, "_drop_cnt"}, 32'(bus.DROP_CNT), 32'd0);
    endtask

    initial begin
        logic ack;
        int first, width;
        bus.RX_STB = 0; bus.RX_DAT = 0; bus.TX_RDY = 1; bus.WR_ACK = 0;
        bus.WD_ACK = 0; bus.RD_ACK = 0; bus.RES_STB = 0; bus.RES_DATA = 0;
        exp_mode = 2'd0; exp_drop = 16'd0; exp_wd = 8'h41;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkResetValues("reset");
        #1 RST = 1'b0;

        // Read command with a delayed RD_ACK.
        sendBytes({8'h72, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0F}, 6, ack);
        checkOutput("rx_ack_idle", 32'(ack), 32'd1);
        measureStb(1'b0, first, width);
        checkOutput("rd_stb_latency", first, 2);
        checkOutput("rd_stb_width", width, 1);
        checkOutput("rd_addr", bus.RD_ADDR, 32'd1);
        checkOutput("rd_len", 32'(bus.RD_LENGTH), 32'h0F);
        repeat (5) @(posedge CLK);
        exp_q.push_back(8'h4B);
        pulseAck(1);
        waitDrain(40);

        // INC pattern and a write command.
        sendBytes({16'h0, 8'h70, 8'h00, 8'h41}, 3, ack);
        exp_q.push_back(8'h4B);
        checkOutput("wd_seed", 32'(bus.WD_DATA), 32'h41);
        sendBytes({8'h77, 8'h00, 8'h00, 8'h16, 8'h00, 8'h03}, 6, ack);
        measureStb(1'b1, first, width);
        checkOutput("wr_stb_latency", first, 2);
        checkOutput("wr_addr", bus.WR_ADDR, 32'h1600);
        checkOutput("wr_len", 32'(bus.WR_LENGTH), 32'd3);
        exp_q.push_back(8'h4B);
        pulseAck(0);
        for (int i = 0; i < 3; i++) begin
            pulseAck(2);
            exp_wd = exp_wd + 8'd1;
            checkOutput("wd_inc", 32'(bus.WD_DATA), 32'(exp_wd));
        end
        waitDrain(40);

        // CONST pattern holds; invalid mode is rejected and changes nothing.
        sendBytes({16'h0, 8'h70, 8'h01, 8'h7A}, 3, ack);
        exp_q.push_back(8'h4B);
        exp_mode = 2'd1; exp_wd = 8'h7A;
        pulseAck(2);
        checkOutput("wd_const", 32'(bus.WD_DATA), 32'(exp_wd));
        sendBytes({16'h0, 8'h70, 8'h03, 8'h55}, 3, ack);
        exp_q.push_back(8'h45);
        checkOutput("wd_bad_mode", 32'(bus.WD_DATA), 32'(exp_wd));
        waitDrain(40);

        // Result stream with a toggling transmitter.
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            bus.RES_STB = 1'b1;
            bus.RES_DATA = 8'(i);
            bus.TX_RDY = i[0];
            exp_q.push_back(8'(i));
        end
        @(posedge CLK); #1;
        bus.RES_STB = 1'b0;
        bus.TX_RDY = 1'b1;
        waitDrain(200);

        // Fill the FIFO with the transmitter stalled: busy threshold, then overflow.
        bus.TX_RDY = 1'b0;
        for (int i = 0; i < 28; i++) begin
            @(posedge CLK); #1;
            bus.RES_STB = 1'b1;
            bus.RES_DATA = 8'(8'h80 + i);
            exp_q.push_back(8'(8'h80 + i));
        end
        @(posedge CLK); #1;
        bus.RES_STB = 1'b0;
        @(negedge CLK);
        checkOutput("res_busy_lag", 32'(bus.RES_BUSY), 32'd0);
        @(negedge CLK);
        checkOutput("res_busy_set", 32'(bus.RES_BUSY), 32'd1);
        for (int i = 28; i < 33; i++) begin
            @(posedge CLK); #1;
            bus.RES_STB = 1'b1;
            bus.RES_DATA = 8'(8'h80 + i);
            if (i < 32) exp_q.push_back(8'(8'h80 + i));
        end
        @(posedge CLK); #1;
        bus.RES_STB = 1'b0;
        exp_drop = exp_drop + 16'd1;
        @(negedge CLK);
        checkOutput("drop_overflow", 32'(bus.DROP_CNT), 32'(exp_drop));
        bus.TX_RDY = 1'b1;
        waitDrain(300);
        checkOutput("res_busy_clear", 32'(bus.RES_BUSY), 32'd0);

        // Argument timeout, then status.
        sendBytes({32'h0, 8'h72, 8'h00}, 2, ack);
        exp_q.push_back(8'h54);
        width = 0;
        for (int i = 0; i < ARG_TO + 20; i++) begin
            @(negedge CLK);
            if (bus.RD_STB) width++;
        end
        checkOutput("timeout_no_rd_stb", width, 0);
        waitDrain(40);
        sendBytes({40'h0, 8'h73}, 1, ack);
        exp_q.push_back(8'h53);
        exp_q.push_back(statusByte());
        waitDrain(40);

        // Unknown opcode, missing WR_ACK with a byte dropped during the wait.
        sendBytes({40'h0, 8'h78}, 1, ack);
        exp_q.push_back(8'h3F);
        waitDrain(40);
        sendBytes({8'h77, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04}, 6, ack);
        applyStimulus(8'h55, ack);
        exp_q.push_back(8'h45);
        exp_drop = exp_drop + 16'd1;
        checkOutput("rx_ack_busy", 32'(ack), 32'd0);
        @(negedge CLK);
        checkOutput("drop_rx", 32'(bus.DROP_CNT), 32'(exp_drop));
        waitDrain(ACK_TO + 60);

        // RD_ACK coincident with RD_STB is accepted.
        sendBytes({8'h72, 8'h00, 8'h00, 8'h00, 8'h09, 8'h02}, 6, ack);
        @(posedge CLK); #1;
        bus.RD_ACK = 1'b1;
        exp_q.push_back(8'h4B);
        @(negedge CLK);
        checkOutput("rd_stb_with_ack", 32'(bus.RD_STB), 32'd1);
        @(posedge CLK); #1;
        bus.RD_ACK = 1'b0;
        waitDrain(40);

        // Reset in the middle of a write frame.
        sendBytes({32'h0, 8'h77, 8'h00}, 2, ack);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkResetValues("midreset");
        #1 RST = 1'b0;
        exp_mode = 2'd0; exp_drop = 16'd0; exp_wd = 8'h41;
        sendBytes({40'h0, 8'h73}, 1, ack);
        exp_q.push_back(8'h53);
        exp_q.push_back(statusByte());
        waitDrain(40);

`ifdef PATTERN_LFSR_EN
        sendBytes({16'h0, 8'h70, 8'h02, 8'h00}, 3, ack);
        exp_q.push_back(8'h4B);
        checkOutput("lfsr_zero_seed", 32'(bus.WD_DATA), 32'h01);
        sendBytes({16'h0, 8'h70, 8'h02, 8'h01}, 3, ack);
        exp_q.push_back(8'h4B);
        exp_mode = 2'd2; exp_wd = 8'h01;
        for (int i = 0; i < 3; i++) begin
            pulseAck(2);
            exp_wd = lfsrStep(exp_wd);
            checkOutput("wd_lfsr", 32'(bus.WD_DATA), 32'(exp_wd));
        end
`else
        sendBytes({16'h0, 8'h70, 8'h02, 8'h01}, 3, ack);
        exp_q.push_back(8'h45);
        checkOutput("mode2_rejected", 32'(bus.WD_DATA), 32'(exp_wd));
`endif
        waitDrain(40);
        sendBytes({40'h0, 8'h73}, 1, ack);
        exp_q.push_back(8'h53);
        exp_q.push_back(statusByte());
        waitDrain(40);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_card_commander.md
Name: uart_card_commander

Overview:
- UART-driven command front-end for the SD card driver; replaces fixed single-character test commands with a byte-framed protocol.
- Each command carries its own address and length, and write commands get a selectable write-data pattern.
- Read results and command replies share one internal FIFO that drains to the UART transmitter.
- Sits between dev_uart_asy (RX/TX strobe interfaces) and card_driver (WR/WD/RD/RES interfaces).

Parameters:
- ADDR_W, 32, address width. Address field is AB=ceil(ADDR_W/8) bytes.
- LEN_W, 8, length width. Length field is LB=ceil(LEN_W/8) bytes.
- FIFO_AW, 5, internal FIFO address width. Depth is 2^FIFO_AW.
- BUSY_MARGIN, 4, RES_BUSY asserted when FIFO count >= depth-BUSY_MARGIN.
- ARG_TIMEOUT, 5000000, max clocks between argument bytes before abort.
- ACK_TIMEOUT, 50000000, max clocks waiting for WR_ACK/RD_ACK.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- RX_STB  in  1  received byte valid (1-cycle)
- RX_DAT  in  8  received byte
- RX_ACK  out  1  byte consumed, same cycle as RX_STB
- TX_STB  out  1  transmit byte strobe (1-cycle)
- TX_DAT  out  8  transmit byte
- TX_RDY  in  1  transmitter idle
- WR_STB  out  1  write request pulse
- WR_ADDR  out  ADDR_W  write address
- WR_LENGTH  out  LEN_W  write length
- WR_ACK  in  1  write accepted
- WD_STB  out  1  write data valid
- WD_DATA  out  8  write data byte
- WD_ACK  in  1  write byte consumed
- RD_STB  out  1  read request pulse
- RD_ADDR  out  ADDR_W  read address
- RD_LENGTH  out  LEN_W  read length
- RD_ACK  in  1  read accepted
- RES_STB  in  1  read result byte valid
- RES_DATA  in  8  read result byte
- RES_BUSY  out  1  FIFO almost full
- DROP_CNT  out  16  bytes dropped (saturating)

Behaviour:
- Reset (synchronous, RST=1 at posedge CLK): all strobes 0, addresses/lengths/TX_DAT 0, FIFO empty, RES_BUSY 0, DROP_CNT 0, WD_STB 1, WD_DATA 8'h41, pattern mode INC, FSM in IDLE. Reset mid-command discards the command with no reply; FIFO contents are lost.
- Frame formats (multi-byte fields MSB first; upper bits beyond ADDR_W/LEN_W discarded):
  - "w" addr[AB] len[LB]: write.
  - "r" addr[AB] len[LB]: read.
  - "p" mode seed: mode 0=INC, 1=CONST, other=ERR; seed loads WD_DATA.
  - "s": status.
- FSM states: IDLE, ARG, ISSUE, WAIT_ACK, REPLY.
- IDLE:
  - "w"/"r" -> ARG with byte count AB+LB; "p" -> ARG with count 2; "s" -> REPLY with byte "S".
  - Any other opcode -> REPLY with "?".
- ARG:
  - Shift each RX byte into the address/length/seed shift register. Count reaching 0 -> ISSUE ("w"/"r"), or apply pattern and REPLY "K" ("p" with valid mode).
  - "p" with invalid mode -> REPLY "E".
  - Gap > ARG_TIMEOUT clocks -> REPLY "T".
- ISSUE: drive the WR_* or RD_* address/length and a 1-cycle WR_STB or RD_STB, then -> WAIT_ACK. Address/length registers hold until the next ISSUE.
- WAIT_ACK:
  - Matching ACK -> REPLY "K".
  - ACK_TIMEOUT elapsed -> REPLY "E".
  - ACK in the same cycle as the STB counts.
- REPLY: push the reply byte into the FIFO when not full, then -> IDLE. If RES_STB arrives in the same cycle, the RES byte is written first and the reply waits one cycle.
- Status "S" is followed by a second byte: {FIFO_full, FIFO_empty, mode[1:0], DROP_CNT[3:0]}.
- RX_ACK=RX_STB in IDLE/ARG. RX_STB in ISSUE/WAIT_ACK/REPLY gets RX_ACK=0 and increments DROP_CNT (saturates at 16'hFFFF).
- Write pattern:
  - WD_STB constant 1.
  - On WD_ACK: INC -> WD_DATA+1, wrapping FF->00; CONST -> unchanged.
  - A "p" load in the same cycle as WD_ACK takes priority.
- FIFO:
  - Synchronous; RES_STB writes when not full. Write when full is dropped and counted in DROP_CNT.
  - RES_BUSY is registered, one cycle after the count crosses the threshold.
- TX drain: when FIFO not empty, TX_RDY=1 and no holdoff, pop and pulse TX_STB with TX_DAT=head. Then enforce a 2-cycle holdoff before the next pop, so stale TX_RDY is ignored.
- Latency: last argument byte to RD_STB/WR_STB is 2 clocks; ACK to "K" at TX_STB is ≤4 clocks when FIFO empty and TX idle.

Optional Feature:
- Macro PATTERN_LFSR_EN.
- Defined: "p" mode 2 selects LFSR pattern. On WD_ACK, WD_DATA <= {WD_DATA[6:0], WD_DATA[7]^WD_DATA[5]^WD_DATA[4]^WD_DATA[3]}. A seed of 00 is loaded as 01.
- Undefined: mode 2 is rejected with "E". The LFSR logic is absent.

Test Plan:
- Read command: RX "r",00,00,00,01,0F -> 1-cycle RD_STB, RD_ADDR=1, RD_LENGTH=15. RD_ACK 5 clocks later -> TX "K".
- Write with INC pattern: RX "p",00,41 -> TX "K". Then "w",00,00,16,00,03 -> WR_ADDR=0x1600, WR_LENGTH=3. Three WD_ACK pulses -> WD_DATA 41,42,43,44.
- Result stream: 20 RES_STB bytes 00..13 with TX_RDY toggling -> TX emits 00..13 in order. RES_BUSY=1 while count ≥28 (depth 32). A 33rd byte written while full -> DROP_CNT=1.
- Argument timeout: RX "r",00, then a gap > ARG_TIMEOUT -> TX "T", FSM in IDLE, no RD_STB. A following "s" -> TX "S" plus status byte.
- Error paths: RX "x" -> "?". RX "w" frame with no WR_ACK -> "E" after ACK_TIMEOUT. RX_STB during WAIT_ACK -> RX_ACK=0, DROP_CNT+1.
- Reset mid-frame: RST after "w",00 -> all outputs at reset values. Next "s" reply has the empty bit set. With PATTERN_LFSR_EN, "p",02,01 then WD_ACK -> WD_DATA=02.
